// File: rtl/fetch_decode_unit.sv
// IF/ID stage of the multi-cycle MIPS core: loadable instruction memory, fetch
// register with PC range fault, and registered field decode with a valid strobe.
module fetch_decode_unit #(
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int STATE_W    = 3,
  parameter int ST_IF      = 0,
  parameter int ST_ID      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state,
  input  logic [31:0]        PC,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [31:0]        load_data,
  output logic [31:0]        instruction,
  output logic [5:0]         opcode,
  output logic [4:0]         rsource,
  output logic [4:0]         rtemp,
  output logic [4:0]         rdestination,
  output logic [4:0]         shamt,
  output logic [5:0]         value_func,
  output logic [15:0]        immediate_value,
  output logic [31:0]        imm_sext,
  output logic [25:0]        jump_target,
  output logic [1:0]         instr_type,
  output logic               decode_valid,
  output logic               pc_fault
);

  localparam logic [STATE_W-1:0] ST_IF_C = STATE_W'(ST_IF);
  localparam logic [STATE_W-1:0] ST_ID_C = STATE_W'(ST_ID);

  logic [31:0] mem_r [IMEM_DEPTH];
  logic        pc_in_range_s;
  logic        is_fetch_s;
  logic        is_decode_s;

  // R-type is opcode 0, J-type is j/jal, everything else is I-type.
  function automatic logic [1:0] classify_format(input logic [5:0] op);
    logic [1:0] fmt;
    case (op)
      6'd0:       fmt = 2'd0;
      6'd2, 6'd3: fmt = 2'd2;
      default:    fmt = 2'd1;
    endcase
    return fmt;
  endfunction

  always_comb begin
    pc_in_range_s = ((PC >> ADDR_W) == 32'd0);
    is_fetch_s    = (state == ST_IF_C);
    is_decode_s   = (state == ST_ID_C);
  end

  // Loader writes ignore rst so a program can be staged while the core is held in reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_r[load_addr] <= load_data;
    end
  end

  // Fetch register: a same-cycle load to the fetched index returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= 32'd0;
      pc_fault    <= 1'b0;
    end else if (is_fetch_s) begin
      if (pc_in_range_s) begin
        instruction <= mem_r[PC[ADDR_W-1:0]];
      end else begin
        instruction <= 32'd0;
        pc_fault    <= 1'b1;
      end
    end
  end

  // Decode registers are fed only from the instruction register.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode          <= 6'd0;
      rsource         <= 5'd0;
      rtemp           <= 5'd0;
      rdestination    <= 5'd0;
      shamt           <= 5'd0;
      value_func      <= 6'd0;
      immediate_value <= 16'd0;
      imm_sext        <= 32'd0;
      jump_target     <= 26'd0;
      instr_type      <= 2'd0;
      decode_valid    <= 1'b0;
    end else begin
      decode_valid <= is_decode_s;
      if (is_decode_s) begin
        opcode          <= instruction[31:26];
        rsource         <= instruction[25:21];
        rtemp           <= instruction[20:16];
        rdestination    <= instruction[15:11];
        shamt           <= instruction[10:6];
        value_func      <= instruction[5:0];
        immediate_value <= instruction[15:0];
        imm_sext        <= {{16{instruction[15]}}, instruction[15:0]};
        jump_target     <= instruction[25:0];
        instr_type      <= classify_format(instruction[31:26]);
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: directed fetch/decode sequences push
// hand-computed expectations; a negedge monitor checks each decode_valid strobe.
module tb_fetch_decode_unit;

  localparam int IMEM_DEPTH = 16;
  localparam int ADDR_W     = 4;
  localparam int STATE_W    = 3;
  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_IDLE = 3'd7;

  logic        clk;
  logic        rst;
  logic [2:0]  state;
  logic [31:0] PC;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] instruction;
  logic [5:0]  opcode;
  logic [4:0]  rsource, rtemp, rdestination, shamt;
  logic [5:0]  value_func;
  logic [15:0] immediate_value;
  logic [31:0] imm_sext;
  logic [25:0] jump_target;
  logic [1:0]  instr_type;
  logic        decode_valid;
  logic        pc_fault;

  fetch_decode_unit #(
    .IMEM_DEPTH(IMEM_DEPTH), .ADDR_W(ADDR_W), .STATE_W(STATE_W), .ST_IF(0), .ST_ID(1)
  ) dut (
    .clk(clk), .rst(rst), .state(state), .PC(PC),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instruction(instruction), .opcode(opcode), .rsource(rsource), .rtemp(rtemp),
    .rdestination(rdestination), .shamt(shamt), .value_func(value_func),
    .immediate_value(immediate_value), .imm_sext(imm_sext), .jump_target(jump_target),
    .instr_type(instr_type), .decode_valid(decode_valid), .pc_fault(pc_fault)
  );

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] sext;
    logic [25:0] jt;
    logic [1:0]  it;
    logic        pf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [5:0] op,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh,
                              input logic [5:0] fn, input logic [15:0] imm,
                              input logic [31:0] sext, input logic [25:0] jt,
                              input logic [1:0] it, input logic pf);
    exp_t e;
    e.instr = instr; e.op = op; e.rs = rs; e.rt = rt; e.rd = rd; e.sh = sh;
    e.fn = fn; e.imm = imm; e.sext = sext; e.jt = jt; e.it = it; e.pf = pf;
    return e;
  endfunction

  // Monitor: every decode_valid strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (decode_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_decode_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("instruction", instruction, e.instr);
        chk("opcode", {26'd0, opcode}, {26'd0, e.op});
        chk("rsource", {27'd0, rsource}, {27'd0, e.rs});
        chk("rtemp", {27'd0, rtemp}, {27'd0, e.rt});
        chk("rdestination", {27'd0, rdestination}, {27'd0, e.rd});
        chk("shamt", {27'd0, shamt}, {27'd0, e.sh});
        chk("value_func", {26'd0, value_func}, {26'd0, e.fn});
        chk("immediate_value", {16'd0, immediate_value}, {16'd0, e.imm});
        chk("imm_sext", imm_sext, e.sext);
        chk("jump_target", {6'd0, jump_target}, {6'd0, e.jt});
        chk("instr_type", {30'd0, instr_type}, {30'd0, e.it});
        chk("pc_fault", {31'd0, pc_fault}, {31'd0, e.pf});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    state = S_IF; PC = pc;
    tick();
  endtask

  // Single ID cycle, then idle; the strobe must drop after exactly one cycle.
  task automatic decode(input exp_t e);
    state = S_ID;
    q.push_back(e);
    tick();
    state = S_IDLE;
    tick();
    chk("decode_valid_one_cycle", {31'd0, decode_valid}, 32'd0);
  endtask

  exp_t e0, e5, e10, e7, e3_old, e3_new, e_nop;

  initial begin
    e0     = mk(32'h8C010000, 6'h23, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0000,
                32'h00000000, 26'h0010000, 2'd1, 1'b0);
    e5     = mk(32'h00A2302A, 6'h00, 5'd5, 5'd2, 5'd6, 5'd0, 6'h2A, 16'h302A,
                32'h0000302A, 26'h0A2302A, 2'd0, 1'b0);
    e10    = mk(32'h14C0FFFD, 6'h05, 5'd6, 5'd0, 5'd31, 5'd31, 6'h3D, 16'hFFFD,
                32'hFFFFFFFD, 26'h0C0FFFD, 2'd1, 1'b0);
    e7     = mk(32'h08000010, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h10, 16'h0010,
                32'h00000010, 26'h0000010, 2'd2, 1'b0);
    e3_old = mk(32'h0C000003, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h03, 16'h0003,
                32'h00000003, 26'h0000003, 2'd2, 1'b0);
    e3_new = mk(32'h24080007, 6'h09, 5'd0, 5'd8, 5'd0, 5'd0, 6'h07, 16'h0007,
                32'h00000007, 26'h0080007, 2'd1, 1'b0);
    e_nop  = mk(32'h00000000, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000,
                32'h00000000, 26'h0000000, 2'd0, 1'b1);

    rst = 1'b1; state = S_IDLE; PC = 32'd0;
    load_en = 1'b0; load_addr = 4'd0; load_data = 32'd0;
    tick();
    // Program is loaded while reset is held.
    load(4'd0, e0.instr);
    load(4'd5, e5.instr);
    load(4'd10, e10.instr);
    load(4'd7, e7.instr);
    load(4'd3, e3_old.instr);
    rst = 1'b0;
    tick();
    chk("reset_instruction", instruction, 32'd0);
    chk("reset_opcode", {26'd0, opcode}, 32'd0);
    chk("reset_imm_sext", imm_sext, 32'd0);
    chk("reset_decode_valid", {31'd0, decode_valid}, 32'd0);
    chk("reset_pc_fault", {31'd0, pc_fault}, 32'd0);

    fetch(32'd0);
    chk("if_no_strobe", {31'd0, decode_valid}, 32'd0);
    decode(e0);
    fetch(32'd5);  decode(e5);
    fetch(32'd10); decode(e10);
    fetch(32'd7);  decode(e7);

    // Same-cycle load and fetch of index 3: old word now, new word on refetch.
    state = S_IF; PC = 32'd3;
    load_en = 1'b1; load_addr = 4'd3; load_data = e3_new.instr;
    tick();
    load_en = 1'b0;
    chk("rbw_old_word", instruction, e3_old.instr);
    decode(e3_old);
    fetch(32'd3);  decode(e3_new);

    // Out-of-range fetch yields a NOP and a sticky fault.
    fetch(32'd16);
    chk("oob_instruction", instruction, 32'd0);
    chk("oob_pc_fault", {31'd0, pc_fault}, 32'd1);
    decode(e_nop);
    e5.pf = 1'b1;
    fetch(32'd5);  decode(e5);
    e5.pf = 1'b0;

    // Reset during ID beats the decode and clears everything.
    fetch(32'd0);
    state = S_ID; rst = 1'b1;
    tick();
    rst = 1'b0; state = S_IDLE;
    chk("rst_id_instruction", instruction, 32'd0);
    chk("rst_id_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_id_rtemp", {27'd0, rtemp}, 32'd0);
    chk("rst_id_jump_target", {6'd0, jump_target}, 32'd0);
    chk("rst_id_instr_type", {30'd0, instr_type}, 32'd0);
    chk("rst_id_decode_valid", {31'd0, decode_valid}, 32'd0);
    chk("rst_id_pc_fault", {31'd0, pc_fault}, 32'd0);
    tick();
    fetch(32'd0);  decode(e0);
    fetch(32'd10); decode(e10);

    tick();
    tick();
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
Parametrised IF/ID block for the multi-cycle MIPS core. It holds a writable instruction memory and latches the word at PC when the controller is in STATE_IF. When the controller is in STATE_ID, it splits that word into fields, sign-extends the immediate and classifies the format. It adds a program loader port, PC range checking, a fault flag and a one-cycle decode-valid strobe.

Parameters:
IMEM_DEPTH, 16, number of 32-bit instruction words (power of two, >= 2)
ADDR_W, 4, index width; must equal log2(IMEM_DEPTH)
STATE_W, 3, width of the controller state bus
ST_IF, 0, state code for instruction fetch
ST_ID, 1, state code for instruction decode

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
state  in  STATE_W  controller state
PC  in  32  word index of the instruction to fetch
load_en  in  1  loader write enable
load_addr  in  ADDR_W  loader write index
load_data  in  32  loader write word
instruction  out  32  fetched instruction register
opcode  out  6  instruction[31:26]
rsource  out  5  instruction[25:21]
rtemp  out  5  instruction[20:16]
rdestination  out  5  instruction[15:11]
shamt  out  5  instruction[10:6]
value_func  out  6  instruction[5:0]
immediate_value  out  16  instruction[15:0]
imm_sext  out  32  immediate sign-extended from bit 15
jump_target  out  26  instruction[25:0]
instr_type  out  2  0=R (opcode 0), 2=J (opcode 2 or 3), 1=I (all other opcodes)
decode_valid  out  1  one-cycle strobe: decoded fields updated this cycle
pc_fault  out  1  sticky flag: a fetch was attempted with PC out of range

Behaviour:
- All state updates occur on the rising edge of clk; rst is sampled only there.
- Reset (rst=1):
  - instruction, all decoded field outputs, imm_sext, instr_type, decode_valid and pc_fault clear to 0.
  - Memory contents are preserved.
  - rst has priority over every other input in the same cycle, including mid-fetch and mid-decode.
- Loader port:
  - load_en=1 writes load_data to mem[load_addr]. It is active in any state, and also while rst=1.
  - Memory is uninitialised until written.
- Fetch (state==ST_IF, rst=0):
  - PC < IMEM_DEPTH: instruction <= mem[PC[ADDR_W-1:0]].
  - Read-before-write: if load_en targets the same index in the same cycle, the old word is fetched and the new word is stored.
  - PC >= IMEM_DEPTH (any of bits 31..ADDR_W set): instruction <= 0 (NOP) and pc_fault <= 1.
  - Decoded outputs hold their values.
- Decode (state==ST_ID, rst=0):
  - All field outputs, imm_sext, jump_target and instr_type load from the current instruction register.
  - decode_valid <= 1 for this edge only.
  - Outputs become visible the cycle after ST_ID is sampled.
- Any other state: all registers hold their values; decode_valid <= 0.
- decode_valid is 0 in every cycle except the one following a sampled ST_ID edge.
  - Consecutive ST_ID cycles re-decode the same word and keep decode_valid high.
- pc_fault stays sticky until rst.
- Latency: PC to decoded fields takes 2 edges (IF then ID).
- Timing: the instruction register is the only path from memory to the decoders.
  - The memory read is synchronous.
  - No output depends combinationally on PC or state.

Test Plan:
- Load mem[0]=0x8C010000, mem[5]=0x00A2302A via loader; IF with PC=0, then ID -> opcode=0x23, rtemp=1, instr_type=1, imm_sext=0, decode_valid=1 for exactly one cycle.
- IF with PC=5, then ID -> opcode=0, rsource=5, rtemp=2, rdestination=6, value_func=0x2A, instr_type=0.
- mem[10]=0x14C0FFFD; IF/ID with PC=10 -> immediate_value=0xFFFD, imm_sext=0xFFFFFFFD, instr_type=1.
- PC=16 with IMEM_DEPTH=16, IF then ID -> instruction=0, opcode=0, pc_fault=1; pc_fault stays 1 through later valid fetches until rst.
- Same-cycle load_en to mem[3] with IF at PC=3 -> old word fetched; a re-fetch of PC=3 returns the new word.
- Assert rst during ST_ID with a loaded instruction -> next cycle all outputs 0, decode_valid=0; memory contents are intact on the next fetch.
